// File: rtl/fp_align_stage.sv
// fp_align_stage: two-stage floating-point operand alignment ahead of an adder.
// S1 unpacks both operands, orders them by magnitude and forms the exponent
// difference; S2 right-shifts the smaller mantissa and collects the sticky bit.
module fp_align_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_lsgn,
   output logic        out_ssgn,
   output logic [7:0]  out_exp,
   output logic [25:0] out_lman,
   output logic [25:0] out_sman,
   output logic        out_sticky,
   output logic        out_nan,
   output logic        out_inf
);

   localparam int DATA_W = 32;
   localparam int MAN_W  = 26;

   // Effective exponent: denormals behave as exponent 1.
   function automatic logic [7:0] eff_exp(input logic [DATA_W-1:0] x);
      eff_exp = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
   endfunction

   // Mantissa with hidden bit and two guard positions below the fraction.
   function automatic logic [MAN_W-1:0] unpack_man(input logic [DATA_W-1:0] x);
      unpack_man = {(x[30:23] != 8'd0), x[22:0], 2'b00};
   endfunction

   // Right shift by d with sticky OR of every bit that falls off the field.
   function automatic logic [MAN_W:0] align_shift(input logic [MAN_W-1:0] man,
                                                  input logic [7:0]       d);
      logic [MAN_W-1:0] lost_mask;
      if (d >= 8'(MAN_W)) begin
         align_shift = {{MAN_W{1'b0}}, |man};
      end else begin
         lost_mask   = ~({MAN_W{1'b1}} << d[4:0]);
         align_shift = {man >> d[4:0], |(man & lost_mask)};
      end
   endfunction

   logic        vld_p1, vld_p2;
   logic        lsgn_p1, ssgn_p1, nan_p1, inf_p1;
   logic [7:0]  exp_p1, d_p1;
   logic [25:0] lman_p1, sman_p1;
   logic        lsgn_p2, ssgn_p2, sticky_p2, nan_p2, inf_p2;
   logic [7:0]  exp_p2;
   logic [25:0] lman_p2, sman_p2;

   logic        s2_load, s1_load;
   logic        a_big, a_nan, b_nan, a_inf, b_inf, nan_c, inf_c;
   logic [31:0] lop, sop;
   logic [7:0]  d_c;
   logic [26:0] shifted_c;

   // Handshake: S2 refills when empty or draining; S1 refills when empty or advancing.
   always_comb begin
      s2_load  = !vld_p2 || out_ready;
      s1_load  = !vld_p1 || s2_load;
      in_ready = !rst && s1_load;
   end

   // Unpack, magnitude compare/swap, exponent difference and special-value flags.
   always_comb begin
      a_big = (a[30:0] > b[30:0]);
      lop   = a_big ? a : b;
      sop   = a_big ? b : a;
      d_c   = eff_exp(lop) - eff_exp(sop);
      a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf = (a[30:0] == 31'h7F80_0000);
      b_inf = (b[30:0] == 31'h7F80_0000);
      nan_c = a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]));
      inf_c = (a_inf || b_inf) && !nan_c;
   end

   // Stage 1 register: ordered operands awaiting alignment.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         lsgn_p1 <= 1'b0;
         ssgn_p1 <= 1'b0;
         exp_p1  <= 8'd0;
         d_p1    <= 8'd0;
         lman_p1 <= 26'd0;
         sman_p1 <= 26'd0;
         nan_p1  <= 1'b0;
         inf_p1  <= 1'b0;
      end else if (s1_load) begin
         vld_p1  <= in_valid;
         lsgn_p1 <= lop[31];
         ssgn_p1 <= sop[31];
         exp_p1  <= eff_exp(lop);
         d_p1    <= d_c;
         lman_p1 <= unpack_man(lop);
         sman_p1 <= unpack_man(sop);
         nan_p1  <= nan_c;
         inf_p1  <= inf_c;
      end
   end

   // Alignment shift of the smaller mantissa.
   always_comb begin
      shifted_c = align_shift(sman_p1, d_p1);
   end

   // Stage 2 register: aligned pair presented to the add stage, held under back-pressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2    <= 1'b0;
         lsgn_p2   <= 1'b0;
         ssgn_p2   <= 1'b0;
         exp_p2    <= 8'd0;
         lman_p2   <= 26'd0;
         sman_p2   <= 26'd0;
         sticky_p2 <= 1'b0;
         nan_p2    <= 1'b0;
         inf_p2    <= 1'b0;
      end else if (s2_load) begin
         vld_p2    <= vld_p1;
         lsgn_p2   <= lsgn_p1;
         ssgn_p2   <= ssgn_p1;
         exp_p2    <= exp_p1;
         lman_p2   <= lman_p1;
         sman_p2   <= shifted_c[26:1];
         sticky_p2 <= shifted_c[0];
         nan_p2    <= nan_p1;
         inf_p2    <= inf_p1;
      end
   end

   assign out_valid  = vld_p2;
   assign out_lsgn   = lsgn_p2;
   assign out_ssgn   = ssgn_p2;
   assign out_exp    = exp_p2;
   assign out_lman   = lman_p2;
   assign out_sman   = sman_p2;
   assign out_sticky = sticky_p2;
   assign out_nan    = nan_p2;
   assign out_inf    = inf_p2;

endmodule
